elevator_request_manager: RTL
=============================

Name: elevator_request_manager

Overview:
- Request-side partner of the elevator state controller.
- Latches car-panel and hall (up/down) call buttons into pending-request registers.
- Presents them to the controller as floor-relative destination vectors (dest_up, dest_down), with arrive and open_out indications.
- Clears requests as they are served, using the controller's floor, direction and door-wait outputs.

Parameters:
N, 20, number of floors; request vectors are N bits.
FW, 5, floor index width; N must not exceed 2**FW.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  reset, synchronous, active-high
car_btn  input  N  car-panel floor buttons, level, one bit per floor
hall_up_btn  input  N  hall up-call buttons
hall_dn_btn  input  N  hall down-call buttons
floor  input  FW  current floor from controller
moving_up  input  1  controller up output
moving_down  input  1  controller down output
door_wait  input  1  controller waitn; car stopped with door cycle active
dest_up  output  N  pending requests strictly above floor
dest_down  output  N  pending requests strictly below floor
arrive  output  1  a stop is required at the current floor
open_out  output  N  pending hall calls (up OR down) per floor
any_req  output  1  OR of all pending requests
fault  output  1  sticky; floor >= N was seen

Behaviour:
- Reset: all request registers, button-history registers, dest_up, dest_down, arrive, open_out, any_req and fault = 0; direction FSM = IDLE.
- Button capture:
  - Each button bit is rising-edge detected against a registered copy of itself.
  - A held button sets its request once only.
  - An edge sets car_req[i], hup_req[i] or hdn_req[i].
- Direction FSM, states IDLE, UP, DOWN:
  - Any state -> UP when moving_up=1; -> DOWN when moving_down=1.
  - If both moving inputs are 1, the state holds and fault is set.
  - UP or DOWN -> IDLE when door_wait=1 and, after this cycle's clears, no request remains anywhere.
- Service clearing (cycle with door_wait=1 and floor < N; f = floor):
  - car_req[f] is cleared.
  - UP: clear hup_req[f]. Also clear hdn_req[f] if no request exists above f.
  - DOWN: clear hdn_req[f]. Also clear hup_req[f] if no request exists below f.
  - IDLE: clear both hup_req[f] and hdn_req[f].
- Set/clear collision on the same bit in the same cycle: clear wins, because a press at the open floor counts as served. Otherwise set wins.
- Outputs (all registered, computed from next-state request registers, so one-cycle latency from button edge to output):
  - all = car_req | hup_req | hdn_req.
  - dest_up[i] = all[i] for i > floor; dest_down[i] = all[i] for i < floor.
  - open_out = hup_req | hdn_req.
  - any_req = |all.
  - arrive = car_req[f], OR the hall call matching the current direction at f, OR (in the reversal case) the opposite hall call at f when nothing lies beyond f in the direction of travel. In IDLE: car_req[f] | hup_req[f] | hdn_req[f].
- Floor boundaries:
  - floor = 0: dest_down = 0.
  - floor = N-1: dest_up = 0.
  - floor >= N: dest_up = dest_down = 0, arrive = 0, no clearing, fault set. fault is sticky until reset.
- Reset asserted mid-operation drops all pending requests within the same cycle. A button still held at reset release does not re-latch until it is released and pressed again.

Test Plan:
- Reset, then idle: all outputs 0; FSM IDLE.
- floor=3, car_btn[7] pulses: the next cycle dest_up=20'h00080 and dest_down=0. Holding the button 10 cycles produces no further change.
- floor=5, hall_dn_btn[2] and car_btn[9] pressed together: dest_down=20'h00004, dest_up=20'h00200, open_out=20'h00004, any_req=1.
- moving_up, floor steps 5->9 with hup_req[9] and car_req[9] pending:
  - arrive=1 at floor 9.
  - door_wait=1 clears both; arrive=0 and any_req=0 the next cycle; FSM -> IDLE.
- Direction UP at floor 4, only hdn_req[4] pending, nothing above: arrive=1; the door_wait cycle clears hdn_req[4]. Repeat with car_req[8] also pending: hdn_req[4] is retained and arrive=0.
- floor=21 (N=20): fault=1 and held, dest outputs 0. hall_up_btn[0] pressed on the same cycle as door_wait at floor 0: request not latched (clear wins). reset mid-request clears everything.

Source files
------------

// File: rtl/elevator_request_manager.sv
// elevator_request_manager
//   Latches car-panel and hall call buttons into pending-request registers and
//   presents them to the elevator state controller relative to the current floor.
//   Requests are cleared as the controller serves them (door_wait at a floor).
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   car_btn            car-panel floor buttons (level)
//   hall_up_btn        hall up-call buttons (level)
//   hall_dn_btn        hall down-call buttons (level)
//   floor              current floor from controller
//   moving_up/down     controller direction outputs
//   door_wait          car stopped with door cycle active
//   dest_up/dest_down  pending requests strictly above / below floor
//   arrive             a stop is required at the current floor
//   open_out           pending hall calls per floor
//   any_req            any request pending
//   fault              sticky: floor out of range or both directions asserted
module elevator_request_manager #(
  parameter int unsigned N  = 20,
  parameter int unsigned FW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  car_btn,
  input  logic [N-1:0]  hall_up_btn,
  input  logic [N-1:0]  hall_dn_btn,
  input  logic [FW-1:0] floor,
  input  logic          moving_up,
  input  logic          moving_down,
  input  logic          door_wait,
  output logic [N-1:0]  dest_up,
  output logic [N-1:0]  dest_down,
  output logic          arrive,
  output logic [N-1:0]  open_out,
  output logic          any_req,
  output logic          fault
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } dir_t;

  dir_t         state, state_d;
  logic [N-1:0] car_req, hup_req, hdn_req;
  logic [N-1:0] car_prev, hup_prev, hdn_prev;
  // Low for the first cycle after reset so buttons held through reset do not latch.
  logic         armed;

  logic         floor_ok;
  logic [N-1:0] f_hot, above, below;
  logic [N-1:0] car_s, hup_s, hdn_s, all_s;
  logic         up_pend_s, dn_pend_s;
  logic [N-1:0] car_clr, hup_clr, hdn_clr;
  logic [N-1:0] car_n, hup_n, hdn_n, all_n;
  logic         car_f, hup_f, hdn_f, up_beyond, dn_beyond;
  logic [N-1:0] dest_up_d, dest_down_d, open_d;
  logic         arrive_d, any_d, fault_d;

  // Next-state request registers, direction and outputs.
  always_comb begin
    floor_ok = 32'(floor) < N;
    f_hot    = '0;
    above    = '0;
    below    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      f_hot[i] = floor_ok && (32'(floor) == i);
      above[i] = i > 32'(floor);
      below[i] = floor_ok && (i < 32'(floor));
    end

    car_s = car_req | (armed ? (car_btn     & ~car_prev) : '0);
    hup_s = hup_req | (armed ? (hall_up_btn & ~hup_prev) : '0);
    hdn_s = hdn_req | (armed ? (hall_dn_btn & ~hdn_prev) : '0);
    all_s = car_s | hup_s | hdn_s;
    up_pend_s = |(all_s & above);
    dn_pend_s = |(all_s & below);

    // The opposite-direction hall call at f is only served when the car will reverse.
    car_clr = '0;
    hup_clr = '0;
    hdn_clr = '0;
    if (door_wait && floor_ok) begin
      car_clr = f_hot;
      if (state == UP) begin
        hup_clr = f_hot;
        hdn_clr = up_pend_s ? '0 : f_hot;
      end else if (state == DOWN) begin
        hdn_clr = f_hot;
        hup_clr = dn_pend_s ? '0 : f_hot;
      end else begin
        hup_clr = f_hot;
        hdn_clr = f_hot;
      end
    end

    // Clear beats a same-cycle set: a press at the open floor counts as served.
    car_n = car_s & ~car_clr;
    hup_n = hup_s & ~hup_clr;
    hdn_n = hdn_s & ~hdn_clr;
    all_n = car_n | hup_n | hdn_n;

    state_d = state;
    if (moving_up && moving_down) begin
      state_d = state;
    end else if (moving_up) begin
      state_d = UP;
    end else if (moving_down) begin
      state_d = DOWN;
    end else if ((state != IDLE) && door_wait && (all_n == '0)) begin
      state_d = IDLE;
    end

    car_f     = |(car_n & f_hot);
    hup_f     = |(hup_n & f_hot);
    hdn_f     = |(hdn_n & f_hot);
    up_beyond = |(all_n & above);
    dn_beyond = |(all_n & below);

    if (state_d == UP) begin
      arrive_d = car_f | hup_f | (hdn_f & ~up_beyond);
    end else if (state_d == DOWN) begin
      arrive_d = car_f | hdn_f | (hup_f & ~dn_beyond);
    end else begin
      arrive_d = car_f | hup_f | hdn_f;
    end

    dest_up_d   = all_n & above;
    dest_down_d = all_n & below;
    open_d      = hup_n | hdn_n;
    any_d       = |all_n;
    fault_d     = fault | ~floor_ok | (moving_up & moving_down);
  end

  // All state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      car_req   <= '0;
      hup_req   <= '0;
      hdn_req   <= '0;
      car_prev  <= '0;
      hup_prev  <= '0;
      hdn_prev  <= '0;
      armed     <= 1'b0;
      dest_up   <= '0;
      dest_down <= '0;
      arrive    <= 1'b0;
      open_out  <= '0;
      any_req   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_d;
      car_req   <= car_n;
      hup_req   <= hup_n;
      hdn_req   <= hdn_n;
      car_prev  <= car_btn;
      hup_prev  <= hall_up_btn;
      hdn_prev  <= hall_dn_btn;
      armed     <= 1'b1;
      dest_up   <= dest_up_d;
      dest_down <= dest_down_d;
      arrive    <= arrive_d;
      open_out  <= open_d;
      any_req   <= any_d;
      fault     <= fault_d;
    end
  end

endmodule
